// File: rtl/bit_serial_subtractor.sv
// bit_serial_subtractor: LSB-first serial a-b over WIDTH cycles; ports clk/rst/start/a/b in, busy/done/diff/borrow/ovf/zero out
module bit_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic [CW-1:0] cnt;
  logic bw, a_msb, b_msb, d, bw_nx, last, accept;
  always_comb begin
    accept = start & (state != BUSY);
    last = cnt == CW'(WIDTH - 1);
    d = a_sr[0] ^ b_sr[0] ^ bw;
    bw_nx = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bw);
    state_nx = accept ? BUSY : (state == BUSY && last) ? DONE : state;
    busy = state == BUSY;
    done = state == DONE;
    diff = done ? res : '0;
    borrow = done & bw;
    ovf = done & (a_msb ^ b_msb) & (res[WIDTH-1] ^ a_msb);
    zero = done & (res == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr <= '0;
      b_sr <= '0;
      res <= '0;
      cnt <= '0;
      bw <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sr <= a;
        b_sr <= b;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
        res <= '0;
        cnt <= '0;
        bw <= 1'b0;
      end else if (state == BUSY) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        res <= {d, res[WIDTH-1:1]};
        cnt <= cnt + CW'(1);
        bw <= bw_nx;
      end
    end
  end
endmodule

// File: tb/tb_bit_serial_subtractor.sv
// tb_bit_serial_subtractor: directed and random checks of bit_serial_subtractor against an arithmetic model
module tb_bit_serial_subtractor;
  localparam int W = 16;
  logic clk = 0, rst = 1, start = 0;
  logic [W-1:0] a = '0, b = '0, diff;
  logic busy, done, borrow, ovf, zero;
  int n_chk = 0, n_fail = 0;
  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ovf(ovf), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_quiet(input string tag, input logic exp_busy);
    chk({tag, " busy"}, 32'(busy), 32'(exp_busy));
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " outs"}, {13'd0, borrow, ovf, zero, diff}, 0);
  endtask
  task automatic chk_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    logic [W-1:0] ed;
    r = int'($signed(x)) - int'($signed(y));
    ed = W'(int'(x) - int'(y));
    chk({tag, " done"}, 32'(done), 1);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " diff"}, 32'(diff), 32'(ed));
    chk({tag, " borrow"}, 32'(borrow), 32'(x < y));
    chk({tag, " ovf"}, 32'(ovf), 32'(r > 32767 || r < -32768));
    chk({tag, " zero"}, 32'(zero), 32'(ed == 0));
  endtask
  task automatic run(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                     input int inj, input int rst_at);
    a = x;
    b = y;
    start = 1;
    tick();
    start = 0;
    a = W'($urandom);
    b = W'($urandom);
    for (int i = 0; i < W; i++) begin
      chk_quiet({tag, " run"}, 1'b1);
      if (i == inj) begin
        start = 1;
        a = W'($urandom);
        b = W'($urandom);
      end
      if (i == rst_at) rst = 1;
      tick();
      start = 0;
      if (i == rst_at) begin
        rst = 0;
        chk_quiet({tag, " after rst"}, 1'b0);
        for (int j = 0; j < W + 4; j++) begin
          tick();
          chk_quiet({tag, " idle"}, 1'b0);
        end
        return;
      end
    end
    chk_result(tag, x, y);
    for (int j = 0; j < 2; j++) begin
      a = W'($urandom);
      b = W'($urandom);
      tick();
      chk_result({tag, " hold"}, x, y);
    end
  endtask
  initial begin
    rst = 1;
    start = 1;
    a = 16'hAAAA;
    b = 16'h5555;
    tick();
    tick();
    chk_quiet("reset", 1'b0);
    start = 0;
    rst = 0;
    tick();
    chk_quiet("idle", 1'b0);
    run("c1", 16'h0005, 16'h0003, -1, -1);
    run("c2", 16'h0003, 16'h0005, -1, -1);
    run("c3", 16'h8000, 16'h0001, -1, -1);
    run("c4", 16'h7FFF, 16'hFFFF, -1, -1);
    run("c5", 16'h1234, 16'h1234, -1, -1);
    run("c6", 16'h0001, 16'h0000, -1, -1);
    run("ign", 16'hBEEF, 16'h1234, 5, -1);
    run("rst", 16'h4321, 16'h1111, -1, 8);
    run("post", 16'h0000, 16'hFFFF, -1, -1);
    run("edge", 16'h0000, 16'h8000, -1, -1);
    for (int k = 0; k < 20; k++) run("rnd", W'($urandom), W'($urandom), -1, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bit_serial_subtractor.md
BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 16, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request a new subtraction; sampled on the rising edge of clk.
REQ-005 Port: a  input  WIDTH  minuend; sampled only on an accepted start.
REQ-006 Port: b  input  WIDTH  subtrahend; sampled only on an accepted start.
REQ-007 Port: busy  output  1  high while the block is in state BUSY.
REQ-008 Port: done  output  1  high while the block is in state DONE (result valid).
REQ-009 Port: diff  output  WIDTH  result a - b, modulo 2^WIDTH.
REQ-010 Port: borrow  output  1  unsigned borrow out; 1 when a < b unsigned.
REQ-011 Port: ovf  output  1  two's-complement signed overflow of a - b.
REQ-012 Port: zero  output  1  high when diff equals 0.

Function
REQ-013 FSM states SHALL be IDLE, BUSY and DONE.
REQ-014 Transitions: IDLE -> BUSY on start; BUSY -> DONE after exactly WIDTH BUSY cycles; DONE -> BUSY on start; DONE holds otherwise.
REQ-015 In IDLE or DONE, start SHALL be accepted: latch a and b into internal shift registers, clear the bit counter and borrow flop, and clear the result register.
REQ-016 Start SHALL be ignored in BUSY; the latched operands and progress stay unaffected.
REQ-017 Each BUSY cycle SHALL process one bit, LSB first: d = a0 ^ b0 ^ bw; bw_next = (~a0 & b0) | (~(a0 ^ b0) & bw).
REQ-018 Each BUSY cycle SHALL shift both operand registers right by one and shift d into the MSB of the result register.
REQ-019 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and increment once per BUSY cycle; the block SHALL leave BUSY when the counter reaches WIDTH-1 on that cycle.
REQ-020 Latency: for start accepted at edge k, done SHALL first be high after edge k+WIDTH, with busy high after edges k .. k+WIDTH-1.
REQ-021 On entry to DONE: diff = result register; borrow = final bw; ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the operand MSBs latched at start; zero = (diff == 0).
REQ-022 diff, borrow, ovf and zero SHALL hold stable throughout DONE until the next accepted start.
REQ-023 The diff, borrow, ovf and zero outputs SHALL read 0 in BUSY and IDLE.
REQ-024 busy and done SHALL never be high in the same cycle.
REQ-025 Changes on a and b outside an accepted start SHALL have no effect.

Reset
REQ-026 rst high at an edge SHALL force state IDLE, overriding start in the same cycle.
REQ-027 rst high at an edge SHALL clear busy, done, diff, borrow, ovf, zero, the counter and all internal registers to 0.
REQ-028 rst asserted mid-BUSY SHALL abort the operation; no done SHALL follow for the aborted operation.

Verification (WIDTH=16)
REQ-029 Case: a=0x0005, b=0x0003, start for 1 cycle -> after 16 edges done=1, diff=0x0002, borrow=0, ovf=0, zero=0.
REQ-030 Case: a=0x0003, b=0x0005 -> diff=0xFFFE, borrow=1, ovf=0, zero=0.
REQ-031 Case: a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1; a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow=1, ovf=1.
REQ-032 Case: a=0x1234, b=0x1234 -> diff=0x0000, zero=1, borrow=0; then start again from DONE with a=1, b=0 -> busy next cycle, later diff=0x0001.
REQ-033 Case: start pulsed again and a/b changed at BUSY cycle 5 -> ignored; the original result is produced at the original cycle.
REQ-034 Case: rst asserted at BUSY cycle 8 -> next cycle all outputs are 0 and state is IDLE; done does not assert without a new start.
